// File: rtl/aoi_sweep_ctrl.sv
// Sweep controller for the 4-input AOI gate unit: drives all 16 input vectors, samples e/f/g and
// scores them against EXP_TABLE. Optional single-step mode is enabled with AOI_SWEEP_STEP_EN.
module aoi_sweep_ctrl #(
  parameter int          SETTLE_CYC = 2,
  parameter logic [47:0] EXP_TABLE  = 48'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
`ifdef AOI_SWEEP_STEP_EN
  input  logic       step,
`endif
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic       fail_seen,
  output logic [3:0] first_fail
);

  // state    | meaning
  // S_IDLE   | waiting for start, results held
  // S_DRIVE  | new vector on a..d, settle counter loaded
  // S_SETTLE | gate outputs settling
  // S_SAMPLE | e/f/g compared at the closing edge
  // S_DONE   | one-cycle done pulse, pass valid
  // S_PAUSE  | single-step wait for step (AOI_SWEEP_STEP_EN only)
  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
`ifdef AOI_SWEEP_STEP_EN
    , S_PAUSE
`endif
  } state_t;

  // A settle time of zero would skip the stable window entirely, so it is raised to one.
  localparam logic [3:0] LP_SETTLE = (SETTLE_CYC < 1)  ? 4'd1  :
                                     (SETTLE_CYC > 15) ? 4'd15 : 4'(SETTLE_CYC);

  state_t     r_state;
  logic [3:0] r_idx;
  logic [3:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [4:0] r_err_cnt;
  logic       r_fail_seen;
  logic [3:0] r_first_fail;

  logic [5:0] w_base;
  logic [2:0] w_exp;
  logic       w_mismatch;
  logic [4:0] w_err_next;

  assign w_base     = {r_idx, 1'b0} + {2'b00, r_idx};
  assign w_exp      = EXP_TABLE[w_base +: 3];
  assign w_mismatch = ({e, f, g} != w_exp);
  assign w_err_next = r_err_cnt + {4'b0000, w_mismatch};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= 4'd0;
      r_cnt        <= 4'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= 5'd0;
      r_fail_seen  <= 1'b0;
      r_first_fail <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state      <= S_DRIVE;
            r_idx        <= 4'd0;
            r_busy       <= 1'b1;
            r_pass       <= 1'b0;
            r_err_cnt    <= 5'd0;
            r_fail_seen  <= 1'b0;
            r_first_fail <= 4'd0;
          end
        end
        S_DRIVE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            r_cnt   <= LP_SETTLE;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (r_cnt <= 4'd1) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_SAMPLE: begin
          // An abort here discards this vector's compare.
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else begin
            if (w_mismatch) begin
              r_err_cnt <= w_err_next;
              if (!r_fail_seen) begin
                r_fail_seen  <= 1'b1;
                r_first_fail <= r_idx;
              end
            end
            if (r_idx == 4'd15) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == 5'd0);
            end else begin
`ifdef AOI_SWEEP_STEP_EN
              r_state <= S_PAUSE;
`else
              r_idx   <= r_idx + 4'd1;
              r_state <= S_DRIVE;
`endif
            end
          end
        end
`ifdef AOI_SWEEP_STEP_EN
        S_PAUSE: begin
          if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
          end else if (step) begin
            r_idx   <= r_idx + 4'd1;
            r_state <= S_DRIVE;
          end
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a          = r_idx[3];
  assign b          = r_idx[2];
  assign c          = r_idx[1];
  assign d          = r_idx[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err_cnt;
  assign fail_seen  = r_fail_seen;
  assign first_fail = r_first_fail;

endmodule

// File: tb/tb_aoi_sweep_ctrl.sv
// Self-checking bench for aoi_sweep_ctrl: a gate model with injectable per-vector faults
// feeds e/f/g, and expected timing/results are computed from the sweep rules.
module tb_aoi_sweep_ctrl;

  localparam int          S   = 2;
  localparam logic [47:0] EXP = 48'h5B3E_96C1_7A24;
`ifdef AOI_SWEEP_STEP_EN
  localparam int P = S + 3;
`else
  localparam int P = S + 2;
`endif
  localparam int DONE_K = 15 * P + S + 2;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       e, f, g, a, b, c, d;
  logic       busy, done, pass, fail_seen;
  logic [4:0] err_cnt;
  logic [3:0] first_fail;
`ifdef AOI_SWEEP_STEP_EN
  logic       step;
`endif

  logic [2:0] mask [16];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  aoi_sweep_ctrl #(.SETTLE_CYC(S), .EXP_TABLE(EXP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef AOI_SWEEP_STEP_EN
    .step(step),
`endif
    .e(e), .f(f), .g(g), .a(a), .b(b), .c(c), .d(d),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .fail_seen(fail_seen), .first_fail(first_fail)
  );

  function automatic logic [2:0] golden(input logic [3:0] i);
    logic [47:0] t;
    t = EXP;
    return t[3*i +: 3];
  endfunction

  // Gate model: correct output for the applied vector, corrupted by that vector's fault mask.
  assign {e, f, g} = golden({a, b, c, d}) ^ mask[{a, b, c, d}];

  function automatic int exp_err(input int upto);
    int n = 0;
    for (int i = 0; i < upto; i++) if (mask[i] != 3'b000) n++;
    return n;
  endfunction

  function automatic int exp_first(input int upto);
    for (int i = 0; i < upto; i++) if (mask[i] != 3'b000) return i;
    return 0;
  endfunction

  function automatic int samples_done(input int k);
    int n;
    if (k < S + 2) return 0;
    n = (k - (S + 2)) / P + 1;
    return (n > 16) ? 16 : n;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) next_cycle();
  endtask

  task automatic kick_start();
    @(negedge clk);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 16; i++) mask[i] = 3'b000;
  endtask

  task automatic rand_mask(input int nfaults);
    clear_mask();
    for (int j = 0; j < nfaults; j++) mask[$urandom_range(15, 0)] = 3'($urandom_range(7, 1));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    adv(2);
    n_tests++;
    if ({a, b, c, d, busy, done, pass, fail_seen, err_cnt, first_fail} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset: outputs=%h required 0", {a, b, c, d, busy, done, pass, fail_seen, err_cnt, first_fail});
    end
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_sweep(input string name, input bit poke_start);
    int n;
    int ev;
    logic ep;
    kick_start();
    for (int k = 0; k <= DONE_K + 3; k++) begin
      ev = (k / P > 15) ? 15 : k / P;
      n  = samples_done(k);
      ep = (k >= DONE_K) && (exp_err(16) == 0);
      n_tests++;
      if ({a, b, c, d} !== 4'(ev)) begin
        n_fail++;
        $display("FAIL %s vector k=%0d: got %0d required %0d", name, k, {a, b, c, d}, ev);
      end
      n_tests++;
      if (busy !== (k < DONE_K) || done !== (k == DONE_K)) begin
        n_fail++;
        $display("FAIL %s busy/done k=%0d: got %b%b required %b%b", name, k, busy, done, k < DONE_K, k == DONE_K);
      end
      n_tests++;
      if (err_cnt !== 5'(exp_err(n)) || fail_seen !== (exp_err(n) > 0) || first_fail !== 4'(exp_first(n))) begin
        n_fail++;
        $display("FAIL %s results k=%0d: got err=%0d seen=%b first=%0d required err=%0d first=%0d",
                 name, k, err_cnt, fail_seen, first_fail, exp_err(n), exp_first(n));
      end
      n_tests++;
      if (pass !== ep) begin
        n_fail++;
        $display("FAIL %s pass k=%0d: got %b required %b", name, k, pass, ep);
      end
      start = (poke_start && k == 20);
      next_cycle();
    end
    start = 1'b0;
  endtask

  task automatic test_abort(input string name, input int at_k, input logic [2:0] m7);
    rand_mask(3);
    mask[7] = m7;
    kick_start();
    adv(at_k);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    for (int j = 0; j < 3 * P; j++) begin
      n_tests++;
      if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || {a, b, c, d} !== 4'd7) begin
        n_fail++;
        $display("FAIL %s idle j=%0d: got busy=%b done=%b pass=%b vec=%0d required 0 0 0 7",
                 name, j, busy, done, pass, {a, b, c, d});
      end
      n_tests++;
      if (err_cnt !== 5'(exp_err(7)) || fail_seen !== (exp_err(7) > 0) || first_fail !== 4'(exp_first(7))) begin
        n_fail++;
        $display("FAIL %s partial j=%0d: got err=%0d first=%0d required err=%0d first=%0d",
                 name, j, err_cnt, first_fail, exp_err(7), exp_first(7));
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid();
    rand_mask(5);
    kick_start();
    adv(40);
    rst_n = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    next_cycle();
    n_tests++;
    if ({a, b, c, d, busy, done, pass, fail_seen, err_cnt, first_fail} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_mid: outputs=%h required 0", {a, b, c, d, busy, done, pass, fail_seen, err_cnt, first_fail});
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    next_cycle();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: busy got %b required 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    clear_mask();
    @(negedge clk);
    start = 1'b1;
    next_cycle();
    adv(DONE_K);
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_done: got done=%b pass=%b required 1 1", done, pass);
    end
    next_cycle();
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: got busy=%b done=%b pass=%b required 0 0 1", busy, done, pass);
    end
    next_cycle();
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1 || pass !== 1'b0 || {a, b, c, d} !== 4'd0) begin
      n_fail++;
      $display("FAIL b2b_restart: got busy=%b pass=%b vec=%0d required 1 0 0", busy, pass, {a, b, c, d});
    end
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_abort_drive: got busy=%b done=%b required 0 0", busy, done);
    end
    next_cycle();
  endtask

`ifdef AOI_SWEEP_STEP_EN
  task automatic test_step();
    clear_mask();
    step = 1'b0;
    kick_start();
    adv(S + 12);
    n_tests++;
    if ({a, b, c, d} !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL step_stall: got vec=%0d busy=%b done=%b required 0 1 0", {a, b, c, d}, busy, done);
    end
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      step = 1'b1;
      next_cycle();
      step = 1'b0;
      n_tests++;
      if ({a, b, c, d} !== 4'(j)) begin
        n_fail++;
        $display("FAIL step_vec: got %0d required %0d", {a, b, c, d}, j);
      end
      adv(S + 2);
    end
    n_tests++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_fail++;
      $display("FAIL step_done: got done=%b pass=%b required 1 1", done, pass);
    end
    adv(2);
    kick_start();
    adv(S + 4);
    abort = 1'b1;
    next_cycle();
    abort = 1'b0;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || {a, b, c, d} !== 4'd0) begin
      n_fail++;
      $display("FAIL step_abort_pause: got busy=%b done=%b vec=%0d required 0 0 0", busy, done, {a, b, c, d});
    end
    step = 1'b1;
    next_cycle();
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
`ifdef AOI_SWEEP_STEP_EN
    step  = 1'b1;
`endif
    clear_mask();
    test_reset();
    clear_mask();
    test_sweep("clean", 1'b0);
    clear_mask();
    mask[5] = 3'b001;
    test_sweep("g_fault_v5", 1'b0);
    for (int i = 0; i < 16; i++) mask[i] = 3'b111;
    test_sweep("all_inverted", 1'b0);
    for (int r = 0; r < 3; r++) begin
      rand_mask($urandom_range(6, 1));
      test_sweep("random", r == 1);
    end
    test_abort("abort_settle", 7 * P + 1, 3'b000);
    test_abort("abort_sample", 7 * P + S + 1, 3'b010);
    test_reset_mid();
    test_back_to_back();
`ifdef AOI_SWEEP_STEP_EN
    test_step();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
